// File: rtl/prm_chk_seq.sv
// rtl/prm_chk_seq.sv - per-point clear/accumulate/readout sequencer for the edge-mask checker
module prm_chk_seq #(
    parameter int FRAMES     = 1,
    parameter int CLR_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        start,
    input  logic        abort,
    input  logic [13:0] xyz_base,
    input  logic [7:0]  xyz_count,
    output logic        chk_rst_n,
    output logic [13:0] xyz_out,
    input  logic [4:0]  data_sel,
    output logic [2:0]  sel1,
    output logic [7:0]  sel2,
    input  logic [31:0] result_imp,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_ACC,
        ST_SEL,
        ST_LOAD,
        ST_HOLD
    } state_t;

    // The first data_sel==0 after a clear merges an empty mask, hence FRAMES+1.
    localparam logic [4:0] FRAME_END = 5'(FRAMES + 1);
    localparam logic [2:0] CLR_LAST  = 3'(CLR_CYCLES - 1);
    localparam logic [6:0] IDX_LAST  = 7'd95;

    state_t      r_state;
    logic [7:0]  r_remaining;
    logic [4:0]  r_frame;
    logic [2:0]  r_clr_cnt;
    logic [6:0]  r_idx;
    logic        r_chk_rst_n;
    logic [13:0] r_xyz;
    logic [2:0]  r_sel1;
    logic [7:0]  r_sel2;
    logic [31:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_last;
    logic        r_done;

    logic        w_last_point;
    logic [6:0]  w_idx_next;

    assign w_last_point = (r_remaining == 8'd1);
    assign w_idx_next   = r_idx + 7'd1;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= 8'd0;
            r_frame     <= 5'd0;
            r_clr_cnt   <= 3'd0;
            r_idx       <= 7'd0;
            r_chk_rst_n <= 1'b1;
            r_xyz       <= 14'd0;
            r_sel1      <= 3'd0;
            r_sel2      <= 8'd0;
            r_out_data  <= 32'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != ST_IDLE && abort) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_chk_rst_n <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_xyz       <= xyz_base;
                            r_remaining <= xyz_count;
                            if (xyz_count == 8'd0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_clr_cnt   <= 3'd0;
                                r_chk_rst_n <= 1'b0;
                                r_state     <= ST_CLR;
                            end
                        end
                    end
                    ST_CLR: begin
                        if (r_clr_cnt == CLR_LAST) begin
                            r_chk_rst_n <= 1'b1;
                            r_frame     <= 5'd0;
                            r_state     <= ST_ACC;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + 3'd1;
                        end
                    end
                    ST_ACC: begin
                        // Reaching FRAME_END costs one extra cycle in ACC before readout.
                        if (r_frame == FRAME_END) begin
                            r_idx   <= 7'd0;
                            r_sel1  <= 3'd0;
                            r_sel2  <= 8'd0;
                            r_state <= ST_SEL;
                        end else if (data_sel == 5'd0) begin
                            r_frame <= r_frame + 5'd1;
                        end
                    end
                    ST_SEL: begin
                        r_state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        r_out_data  <= result_imp;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_idx == IDX_LAST) && w_last_point;
                        r_state     <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (r_idx != IDX_LAST) begin
                                r_idx   <= w_idx_next;
                                r_sel1  <= w_idx_next[6:4];
                                r_sel2  <= {4'd0, w_idx_next[3:0]};
                                r_state <= ST_SEL;
                            end else begin
                                r_remaining <= r_remaining - 8'd1;
                                if (w_last_point) begin
                                    r_done  <= 1'b1;
                                    r_state <= ST_IDLE;
                                end else begin
                                    r_xyz       <= r_xyz + 14'd1;
                                    r_clr_cnt   <= 3'd0;
                                    r_chk_rst_n <= 1'b0;
                                    r_state     <= ST_CLR;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign chk_rst_n = r_chk_rst_n;
    assign xyz_out   = r_xyz;
    assign sel1      = r_sel1;
    assign sel2      = r_sel2;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_prm_chk_seq.sv
// tb/tb_prm_chk_seq.sv - randomized self-checking bench for prm_chk_seq against a word-stream model
`timescale 1ns/1ps
module tb_prm_chk_seq;
    localparam int FRAMES     = 1;
    localparam int CLR_CYCLES = 2;
    localparam int WPP        = 96;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [13:0] xyz_base = 14'd0;
    logic [7:0]  xyz_count = 8'd0;
    logic        chk_rst_n;
    logic [13:0] xyz_out;
    logic [4:0]  data_sel;
    logic [2:0]  sel1;
    logic [7:0]  sel2;
    logic [31:0] result_imp;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    prm_chk_seq #(.FRAMES(FRAMES), .CLR_CYCLES(CLR_CYCLES)) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .abort(abort),
        .xyz_base(xyz_base), .xyz_count(xyz_count), .chk_rst_n(chk_rst_n),
        .xyz_out(xyz_out), .data_sel(data_sel), .sel1(sel1), .sel2(sel2),
        .result_imp(result_imp), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Checker readout: a fixed hash of the point and the flat word index.
    function automatic logic [31:0] mix(input logic [13:0] x, input int idx);
        logic [31:0] h;
        h = ({18'd0, x} * 32'h9E3779B1) + (32'(idx) * 32'h85EBCA6B) + 32'h0BADF00D;
        return h ^ (h >> 13);
    endfunction

    assign result_imp = mix(xyz_out, int'(sel1) * 16 + int'(sel2));

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_mode = 0;
    bit chk_en = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(act === exp, name, act, exp);
    endtask

    initial begin
        data_sel  = 5'($urandom);
        out_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            data_sel = data_sel + 5'd1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: out_ready = 1'b0;
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [13:0] x;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    exp_t        t;
    logic [13:0] xyz_log[$];
    bit          m_active = 1'b0;
    bit          m_done_exp = 1'b0;
    bit          m_stab = 1'b0;
    bit          acc_now;
    bit          acc_on = 1'b0;
    bit          pend = 1'b0;
    int          run = 0;
    int          m_runs = 0;
    int          m_runs_exp = 0;
    int          zcnt = 0;
    int          first_exp = 0;
    int          n_words = 0;
    logic [31:0] p_data;
    logic        p_last;
    logic [2:0]  p_sel1;
    logic [7:0]  p_sel2;

    always @(negedge CLK) begin
        if (chk_en) begin
            chk_eq("busy", 32'(busy), 32'(m_active));
            chk_eq("done", 32'(done), 32'(m_done_exp));
            if (out_last) check(out_valid, "last_without_valid", 32'(out_valid), 32'd1);
            if (m_stab)
                check(out_valid && out_data === p_data && out_last === p_last && sel1 === p_sel1 && sel2 === p_sel2,
                      "hold_stable", out_data, p_data);

            if (!chk_rst_n) begin
                check(m_active, "clr_outside_sweep", 32'(chk_rst_n), 32'd1);
                if (run == 0) xyz_log.push_back(xyz_out);
                if (q.size() > 0) chk_eq("clr_xyz", 32'(xyz_out), 32'(q[0].x));
                run++;
            end else if (run > 0) begin
                chk_eq("clr_len", 32'(run), 32'(CLR_CYCLES));
                run    = 0;
                m_runs++;
                acc_on = 1'b1;
                zcnt   = 0;
            end
            if (acc_on && data_sel == 5'd0) begin
                zcnt++;
                if (zcnt == FRAMES + 1) begin
                    acc_on    = 1'b0;
                    pend      = 1'b1;
                    first_exp = cyc + 4;
                end
            end
            if (pend && cyc == first_exp) begin
                check(out_valid, "acc_latency", 32'(out_valid), 32'd1);
                pend = 1'b0;
            end else if (acc_on || pend) begin
                check(!out_valid, "early_valid", 32'(out_valid), 32'd0);
            end

            acc_now = RST_n && !abort && out_valid && out_ready;
            if (acc_now) begin
                check(q.size() > 0, "extra_word", out_data, 32'd0);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk_eq("word_data", out_data, e.d);
                    chk_eq("word_last", 32'(out_last), 32'(e.l));
                    chk_eq("word_xyz", 32'(xyz_out), 32'(e.x));
                    n_words++;
                end
            end

            m_stab = RST_n && !abort && out_valid && !out_ready;
            p_data = out_data;
            p_last = out_last;
            p_sel1 = sel1;
            p_sel2 = sel2;

            m_done_exp = 1'b0;
            if (!RST_n || (m_active && abort)) begin
                m_active = 1'b0;
                q.delete();
                run    = 0;
                acc_on = 1'b0;
                pend   = 1'b0;
            end else if (!m_active && start && !abort) begin
                if (xyz_count == 8'd0) begin
                    m_done_exp = 1'b1;
                end else begin
                    m_active   = 1'b1;
                    m_runs     = 0;
                    m_runs_exp = int'(xyz_count);
                    for (int p = 0; p < int'(xyz_count); p++) begin
                        for (int i = 0; i < WPP; i++) begin
                            t.x = xyz_base + 14'(p);
                            t.d = mix(t.x, i);
                            t.l = (i == WPP - 1) && (p == int'(xyz_count) - 1);
                            q.push_back(t);
                        end
                    end
                end
            end else if (m_active && acc_now && q.size() == 0) begin
                m_active   = 1'b0;
                m_done_exp = 1'b1;
                chk_eq("clr_runs", 32'(m_runs), 32'(m_runs_exp));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic go(input logic [13:0] base, input logic [7:0] cnt);
        start     = 1'b1;
        xyz_base  = base;
        xyz_count = cnt;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick(1);
            k++;
        end
        check(done, name, 32'(k), 32'(budget));
    endtask

    task automatic check_reset_outputs(input string name);
        check(chk_rst_n === 1'b1 && xyz_out === 14'd0 && sel1 === 3'd0 && sel2 === 8'd0 &&
              out_data === 32'd0 && out_valid === 1'b0 && out_last === 1'b0 && busy === 1'b0 && done === 1'b0,
              name, {out_valid, out_last, busy, done, chk_rst_n, 3'd0, sel1, 7'd0, xyz_out}, 32'h0800_0000);
    endtask

    int w0;
    int k;

    initial begin
        tick(1);
        chk_en = 1'b1;
        tick(2);
        check_reset_outputs("reset_outputs");
        RST_n = 1'b1;
        tick(2);

        // single point, full-rate sink
        ready_mode = 0;
        w0 = n_words;
        go(14'h0123, 8'd1);
        wait_done(3000, "s1_done_timeout");
        chk_eq("s1_words", 32'(n_words - w0), 32'd96);
        tick(1);
        chk_eq("s1_busy_after", 32'(busy), 32'd0);

        // three points wrapping through 0x3FFF
        xyz_log.delete();
        w0 = n_words;
        go(14'h3FFF, 8'd3);
        wait_done(6000, "s2_done_timeout");
        chk_eq("s2_words", 32'(n_words - w0), 32'd288);
        chk_eq("s2_points", 32'(xyz_log.size()), 32'd3);
        if (xyz_log.size() == 3) begin
            chk_eq("s2_xyz0", 32'(xyz_log[0]), 32'h3FFF);
            chk_eq("s2_xyz1", 32'(xyz_log[1]), 32'h0000);
            chk_eq("s2_xyz2", 32'(xyz_log[2]), 32'h0001);
        end
        tick(2);

        // random backpressure with a long stall and an ignored start
        ready_mode = 1;
        w0 = n_words;
        go(14'($urandom), 8'd2);
        tick(150);
        go(14'h2222, 8'd7);
        ready_mode = 2;
        tick(20);
        ready_mode = 1;
        wait_done(8000, "s3_done_timeout");
        chk_eq("s3_words", 32'(n_words - w0), 32'd192);
        tick(2);

        // abort while holding word 40, then a clean rerun
        ready_mode = 3;
        out_ready  = 1'b1;
        w0 = n_words;
        go(14'($urandom), 8'd2);
        k = 0;
        while (n_words - w0 < 40 && k < 3000) begin
            tick(1);
            k++;
        end
        out_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin
            tick(1);
            k++;
        end
        check(out_valid, "s4_reach_word40", 32'(k), 32'd100);
        tick(2);
        chk_eq("s4_idx40_sel", {21'd0, sel1, sel2}, {21'd0, 3'd2, 8'd8});
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk_eq("s4_abort_valid", 32'(out_valid), 32'd0);
        chk_eq("s4_abort_busy", 32'(busy), 32'd0);
        tick(10);
        chk_eq("s4_words", 32'(n_words - w0), 32'd40);
        ready_mode = 0;
        w0 = n_words;
        go(14'($urandom), 8'd1);
        wait_done(3000, "s4_rerun_timeout");
        chk_eq("s4_rerun_words", 32'(n_words - w0), 32'd96);
        tick(2);

        // empty sweep
        go(14'($urandom), 8'd0);
        chk_eq("s5_done", 32'(done), 32'd1);
        tick(1);
        chk_eq("s5_done_once", 32'(done), 32'd0);
        tick(3);

        // start while busy, then reset during ACC
        go(14'h0AAA, 8'd2);
        tick(2);
        go(14'h1555, 8'd5);
        tick(5);
        chk_eq("s6_xyz_kept", 32'(xyz_out), 32'h0AAA);
        check(busy && chk_rst_n && !out_valid, "s6_in_acc", {29'd0, busy, chk_rst_n, out_valid}, 32'd6);
        RST_n = 1'b0;
        tick(1);
        check_reset_outputs("s6_reset_outputs");
        tick(1);
        RST_n = 1'b1;
        tick(3);

        // random sweeps
        for (int r = 0; r < 3; r++) begin
            ready_mode = 1;
            w0 = n_words;
            go(14'($urandom), 8'($urandom_range(1, 2)));
            wait_done(8000, "rand_done_timeout");
            tick(int'($urandom_range(1, 4)));
        end

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
